// File: rtl/xadc_drp_seq.sv
// xadc_drp_seq
//   XADC DRP read sequencer. On each end-of-conversion pulse, reads the next
//   auxiliary-channel status register from a round-robin address list. The
//   12-bit code is presented with a channel tag and a one-cycle valid strobe.
//   A hung DRP is detected by a timeout. A conversion that arrives while a
//   read is in flight is reported as an overrun and dropped.
//
// Optional build macro: XADC_DRP_AVG_EN
//   Adds per-channel averaging over 2**AVG_LOG2 samples. Only the averaged
//   result is strobed out.
//
// Ports
//   i_clk            system clock (also the XADC dclk)
//   i_rst_n          asynchronous active-low reset
//   i_enable         run; low parks the block in IDLE after any read completes
//   i_eoc            XADC end-of-conversion pulse
//   o_den/o_dwe      DRP enable / write enable (dwe tied low)
//   o_daddr          DRP address, held for the whole read
//   o_di             DRP write data (tied low)
//   i_drdy/i_do_in   DRP ready / read data
//   o_sample_valid   one-cycle strobe for o_sample_data/o_sample_ch
//   o_sample_data    ADC code (do_in[15:4])
//   o_sample_ch      index into ADDR_LIST of the result
//   o_timeout_err    one-cycle pulse when a read is aborted
//   o_overrun        one-cycle pulse for an eoc dropped outside WAIT_EOC
//   o_busy           high while a DRP read is outstanding
module xadc_drp_seq #(
  parameter int unsigned         NUM_CH      = 2,
  parameter logic [NUM_CH*7-1:0] ADDR_LIST   = {7'h17, 7'h16},
  parameter int unsigned         TIMEOUT_CYC = 64,
  parameter int unsigned         AVG_LOG2    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_eoc,
  output logic        o_den,
  output logic        o_dwe,
  output logic [6:0]  o_daddr,
  output logic [15:0] o_di,
  input  logic        i_drdy,
  input  logic [15:0] i_do_in,
  output logic        o_sample_valid,
  output logic [11:0] o_sample_data,
  output logic [1:0]  o_sample_ch,
  output logic        o_timeout_err,
  output logic        o_overrun,
  output logic        o_busy
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 2;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_EOC, S_ISSUE, S_WAIT_RDY, S_REPORT
  } state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [TW-1:0] r_timer;
  logic [6:0]    r_daddr, w_addr;
  logic [11:0]   r_data, w_code;
  logic [1:0]    r_ch;
  logic          r_overrun;
  logic          w_tmo_hit;
  logic          w_take;

  assign w_idx_nxt = (r_idx == 2'(NUM_CH - 1)) ? '0 : r_idx + 2'd1;
  assign w_take    = (r_state == S_WAIT_RDY) && i_drdy;
  // drdy has priority over the timeout in the final cycle.
  assign w_tmo_hit = (r_state == S_WAIT_RDY) && !i_drdy &&
                     (r_timer == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_addr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (r_idx == 2'(i)) w_addr = ADDR_LIST[7*i +: 7];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_enable) w_next = S_WAIT_EOC;
      S_WAIT_EOC: begin
        if (!i_enable)  w_next = S_IDLE;
        else if (i_eoc) w_next = S_ISSUE;
      end
      S_ISSUE:    w_next = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (i_drdy)         w_next = S_REPORT;
        else if (w_tmo_hit) w_next = i_enable ? S_WAIT_EOC : S_IDLE;
      end
      S_REPORT:   w_next = i_enable ? S_WAIT_EOC : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_timer   <= '0;
      r_daddr   <= '0;
      r_data    <= '0;
      r_ch      <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      // An eoc in IDLE is still an overrun while enabled.
      r_overrun <= i_eoc && (r_state != S_WAIT_EOC) &&
                   !((r_state == S_IDLE) && !i_enable);
      if ((r_state == S_WAIT_EOC) && (w_next == S_ISSUE)) r_daddr <= w_addr;
      if (r_state == S_ISSUE)         r_timer <= '0;
      else if (r_state == S_WAIT_RDY) r_timer <= r_timer + TW'(1);
      if (w_take) begin
        r_data <= w_code;
        r_ch   <= r_idx;
      end
      if (w_tmo_hit || (r_state == S_REPORT)) r_idx <= w_idx_nxt;
    end
  end

`ifdef XADC_DRP_AVG_EN
  localparam int unsigned AW = 12 + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;

  logic [AW-1:0] r_acc [4];
  logic [CW-1:0] r_cnt [4];
  logic          r_emit;
  logic [AW-1:0] w_sum;

  assign w_sum  = r_acc[r_idx] + AW'(i_do_in[15:4]);
  assign w_code = 12'(w_sum >> AVG_LOG2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
      r_emit <= 1'b0;
    end else if (r_state == S_IDLE) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
      r_emit <= 1'b0;
    end else if (w_take) begin
      if (r_cnt[r_idx] == CW'((1 << AVG_LOG2) - 1)) begin
        r_acc[r_idx] <= '0;
        r_cnt[r_idx] <= '0;
        r_emit       <= 1'b1;
      end else begin
        r_acc[r_idx] <= w_sum;
        r_cnt[r_idx] <= r_cnt[r_idx] + CW'(1);
        r_emit       <= 1'b0;
      end
    end
  end

  assign o_sample_valid = (r_state == S_REPORT) && r_emit;
`else
  logic w_unused;
  assign w_unused       = ^{i_do_in[3:0], AVG_LOG2[0]};
  assign w_code         = i_do_in[15:4];
  assign o_sample_valid = (r_state == S_REPORT);
`endif

  assign o_den         = (r_state == S_ISSUE);
  assign o_dwe         = 1'b0;
  assign o_di          = '0;
  assign o_daddr       = r_daddr;
  assign o_sample_data = r_data;
  assign o_sample_ch   = r_ch;
  assign o_timeout_err = w_tmo_hit;
  assign o_overrun     = r_overrun;
  assign o_busy        = (r_state == S_ISSUE) || (r_state == S_WAIT_RDY);

endmodule

// File: tb/tb_xadc_drp_seq.sv
// Scoreboarded bench for xadc_drp_seq in the default build (no averaging).
module tb_xadc_drp_seq;

  logic        clk = 1'b0;
  logic        rst_n, enable, eoc, drdy;
  logic [15:0] do_in;
  logic        den, dwe, sample_valid, timeout_err, overrun, busy;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [11:0] sample_data;
  logic [1:0]  sample_ch;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int den_cyc = 0;

  logic [6:0]  q_addr[$];
  logic [13:0] q_samp[$];
  int          q_tmo[$];

  xadc_drp_seq #(
    .NUM_CH(2),
    .ADDR_LIST({7'h17, 7'h16}),
    .TIMEOUT_CYC(64),
    .AVG_LOG2(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_eoc(eoc),
    .o_den(den), .o_dwe(dwe), .o_daddr(daddr), .o_di(di),
    .i_drdy(drdy), .i_do_in(do_in),
    .o_sample_valid(sample_valid), .o_sample_data(sample_data),
    .o_sample_ch(sample_ch), .o_timeout_err(timeout_err),
    .o_overrun(overrun), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected DRP addresses, samples and timeout delays.
  always @(negedge clk) begin
    if (rst_n) begin
      if (den) begin
        den_cyc = cyc;
        if (q_addr.size() == 0) chk("unexpected_den", 1'b1, 1'b0);
        else begin
          chk("den_daddr", {57'd0, daddr}, {57'd0, q_addr.pop_front()});
          chk("den_dwe", {63'd0, dwe}, 64'd0);
        end
      end
      if (sample_valid) begin
        if (q_samp.size() == 0) chk("unexpected_sample", 1'b1, 1'b0);
        else chk("sample_ch_data", {50'd0, sample_ch, sample_data},
                 {50'd0, q_samp.pop_front()});
      end
      if (timeout_err) begin
        if (q_tmo.size() == 0) chk("unexpected_timeout", 1'b1, 1'b0);
        else chk("timeout_delay", 64'(cyc - den_cyc), 64'(q_tmo.pop_front()));
      end
    end
  end

  // eoc, then drdy in cycle 'gap' counted from the den cycle (cycle 0).
  task automatic do_read(input logic [15:0] d, input int gap);
    eoc = 1'b1; tick(); eoc = 1'b0;
    repeat (gap) tick();
    drdy = 1'b1; do_in = d; tick(); drdy = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; eoc = 1'b0; drdy = 1'b0; do_in = '0;
    repeat (3) tick();
    chk("reset_outputs", {den, dwe, daddr, di, sample_valid, sample_data,
        sample_ch, timeout_err, overrun, busy}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single read with explicit latency checks.
    enable = 1'b1; tick();
    q_addr.push_back(7'h16); q_samp.push_back({2'd0, 12'hABC});
    eoc = 1'b1;
    chk("den_low_in_eoc_cycle", den, 1'b0);
    tick(); eoc = 1'b0;
    chk("den_after_eoc", den, 1'b1);
    chk("busy_in_issue", busy, 1'b1);
    tick();
    chk("den_one_cycle", den, 1'b0);
    tick(); tick();
    drdy = 1'b1; do_in = 16'hABC0;
    chk("no_valid_before_drdy", sample_valid, 1'b0);
    tick(); drdy = 1'b0;
    chk("valid_after_drdy", sample_valid, 1'b1);
    tick();
    chk("valid_one_cycle", sample_valid, 1'b0);

    // Round robin continues: 7'h17 ch1, 7'h16 ch0, 7'h17 ch1.
    q_addr.push_back(7'h17); q_samp.push_back({2'd1, 12'h555});
    do_read(16'h555F, 1);
    q_addr.push_back(7'h16); q_samp.push_back({2'd0, 12'h001});
    do_read(16'h0010, 5);
    q_addr.push_back(7'h17); q_samp.push_back({2'd1, 12'hFFF});
    do_read(16'hFFF3, 2);

    // Timeout on channel 0.
    q_addr.push_back(7'h16); q_tmo.push_back(64);
    eoc = 1'b1; tick(); eoc = 1'b0;
    repeat (63) tick();
    chk("no_timeout_at_63", timeout_err, 1'b0);
    tick();
    chk("timeout_at_64", timeout_err, 1'b1);
    chk("no_valid_on_timeout", sample_valid, 1'b0);
    tick();
    chk("idle_after_timeout", busy, 1'b0);
    // drdy on the last timer cycle wins over the timeout.
    q_addr.push_back(7'h17); q_samp.push_back({2'd1, 12'h7E5});
    do_read(16'h7E50, 64);

    // Overrun during WAIT_RDY, then enable drop before drdy.
    q_addr.push_back(7'h16); q_samp.push_back({2'd0, 12'h123});
    eoc = 1'b1; tick(); eoc = 1'b0;
    tick();
    eoc = 1'b1; tick(); eoc = 1'b0;
    chk("overrun_pulse", overrun, 1'b1);
    enable = 1'b0;
    tick();
    chk("overrun_one_cycle", overrun, 1'b0);
    drdy = 1'b1; do_in = 16'h1230; tick(); drdy = 1'b0;
    tick();
    chk("idle_after_disable", busy, 1'b0);
    eoc = 1'b1; tick(); eoc = 1'b0;
    chk("no_overrun_idle_disabled", overrun, 1'b0);
    tick(); tick();
    chk("no_den_when_disabled", {den, busy}, 2'b00);

    // Reset mid-read; stray drdy afterwards ignored; index back to 0.
    enable = 1'b1; tick();
    q_addr.push_back(7'h17);
    eoc = 1'b1; tick(); eoc = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {den, daddr, sample_valid, sample_data,
        sample_ch, timeout_err, overrun, busy}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    drdy = 1'b1; do_in = 16'hEEE0; tick(); tick(); drdy = 1'b0;
    chk("stray_drdy_ignored", {sample_valid, busy}, 2'b00);
    q_addr.push_back(7'h16); q_samp.push_back({2'd0, 12'h456});
    do_read(16'h4560, 2);

    repeat (3) tick();
    chk("addr_queue_drained", 64'(q_addr.size()), 64'd0);
    chk("sample_queue_drained", 64'(q_samp.size()), 64'd0);
    chk("timeout_queue_drained", 64'(q_tmo.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
